sobel_window_seq_ctrl: RTL and testbench

- Sequencer in front of the 3x3 line-buffer window generator in the OV5640 Sobel/erosion/dilation pipeline.
- Tracks frame/row/column position of incoming pixels and gates the line-buffer clock enable.
- Suppresses windows during line-buffer priming, and drains the last image row with a synthetic flush line.
- Emits a window-valid strobe with centre coordinates and border flags so downstream kernels handle edges.

---
 rtl/sobel_window_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_sobel_window_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_seq_ctrl.sv
// Position sequencer ahead of the 3x3 line-buffer window generator: primes row 0,
// streams pixels, drains the last row with a zero flush line, and tags window centres.
module sobel_window_seq_ctrl #(
    parameter int unsigned IMG_W = 1024,
    parameter int unsigned IMG_H = 768,
    parameter int unsigned CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          pix_en_in,
    input  logic [7:0]    pix_data_in,
    output logic          lb_en,
    output logic [7:0]    lb_data,
    output logic          win_valid,
    output logic [CW-1:0] center_col,
    output logic [CW-1:0] center_row,
    output logic [3:0]    border,
    output logic          busy,
    output logic          frame_done,
    output logic          err_abort,
    output logic          err_overrun
);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_PRE   = CW'(IMG_W - 2);
    localparam logic [CW-1:0] ROW_LAST  = CW'(IMG_H - 1);
    localparam logic [CW-1:0] ROW_FLUSH = CW'(IMG_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t        state, state_nxt, eff_state;
    logic [CW-1:0] in_col, in_col_nxt, in_row, in_row_nxt;
    logic [CW-1:0] flush_col, flush_col_nxt;
    logic [CW-1:0] eff_col, eff_row;
    logic [CW-1:0] win_r, win_c, ctr_r, ctr_c;
    logic          flush_last, fresh;
    logic          wv_nxt, done_nxt, abort_nxt, overrun_nxt;
    logic [3:0]    border_nxt;

    // Next-state, line-buffer drive and window tagging
    always_comb begin
        state_nxt     = state;
        in_col_nxt    = in_col;
        in_row_nxt    = in_row;
        flush_col_nxt = flush_col;
        lb_en         = 1'b0;
        lb_data       = 8'd0;
        overrun_nxt   = 1'b0;
        win_r         = '0;
        win_c         = '0;

        // The last flush cycle always completes so the frame's final window is not lost
        flush_last = (state == FLUSH) && (flush_col == COL_LAST);
        fresh      = frame_start && !flush_last;
        eff_state  = fresh ? PRIME : state;
        eff_col    = fresh ? '0 : in_col;
        eff_row    = fresh ? '0 : in_row;
        abort_nxt  = fresh && (state != IDLE);

        if (fresh) begin
            state_nxt     = PRIME;
            in_col_nxt    = '0;
            in_row_nxt    = '0;
            flush_col_nxt = '0;
        end

        case (eff_state)
            IDLE: begin
                overrun_nxt = pix_en_in;
            end
            PRIME, RUN: begin
                lb_en   = pix_en_in;
                lb_data = pix_data_in;
                win_r   = eff_row;
                win_c   = eff_col;
                if (pix_en_in) begin
                    if (eff_col == COL_LAST) begin
                        in_col_nxt = '0;
                        if (eff_row == ROW_LAST) begin
                            state_nxt     = FLUSH;
                            in_row_nxt    = '0;
                            flush_col_nxt = '0;
                        end else begin
                            state_nxt  = RUN;
                            in_row_nxt = eff_row + CW'(1);
                        end
                    end else begin
                        in_col_nxt = eff_col + CW'(1);
                    end
                end
            end
            FLUSH: begin
                lb_en       = 1'b1;
                overrun_nxt = pix_en_in;
                win_r       = ROW_FLUSH;
                win_c       = flush_col;
                if (flush_last) begin
                    flush_col_nxt = '0;
                    state_nxt     = frame_start ? PRIME : IDLE;
                end else begin
                    flush_col_nxt = flush_col + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        ctr_r      = win_r - CW'(1);
        ctr_c      = win_c - CW'(1);
        wv_nxt     = lb_en && (win_r != '0) && (win_c != '0);
        done_nxt   = flush_last;
        border_nxt = {ctr_r == '0, ctr_r == ROW_LAST, ctr_c == '0, ctr_c == COL_PRE};
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_col      <= '0;
            in_row      <= '0;
            flush_col   <= '0;
            win_valid   <= 1'b0;
            center_col  <= '0;
            center_row  <= '0;
            border      <= 4'd0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_abort   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_col      <= in_col_nxt;
            in_row      <= in_row_nxt;
            flush_col   <= flush_col_nxt;
            win_valid   <= wv_nxt;
            busy        <= (state_nxt != IDLE);
            frame_done  <= done_nxt;
            err_abort   <= abort_nxt;
            err_overrun <= overrun_nxt;
            if (wv_nxt) begin
                center_col <= ctr_c;
                center_row <= ctr_r;
                border     <= border_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_seq_ctrl.sv
// Directed bench for sobel_window_seq_ctrl on an 8x4 image: full frames, gapped input,
// abort, flush overrun, async reset and chained frames.
module tb_sobel_window_seq_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          pix_en_in = 1'b0;
    logic [7:0]    pix_data_in = 8'd0;
    logic          lb_en;
    logic [7:0]    lb_data;
    logic          win_valid;
    logic [CW-1:0] center_col;
    logic [CW-1:0] center_row;
    logic [3:0]    border;
    logic          busy;
    logic          frame_done;
    logic          err_abort;
    logic          err_overrun;

    sobel_window_seq_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .pix_en_in(pix_en_in), .pix_data_in(pix_data_in),
        .lb_en(lb_en), .lb_data(lb_data), .win_valid(win_valid),
        .center_col(center_col), .center_row(center_row), .border(border),
        .busy(busy), .frame_done(frame_done), .err_abort(err_abort),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_lb, n_zero, n_wv, n_fd, n_abort, n_ovr, n_orphan, first_lb;
    int exp_r, exp_c;
    logic [3:0] first_border, fd_border;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_mon();
        n_lb = 0; n_zero = 0; n_wv = 0; n_fd = 0; n_abort = 0; n_ovr = 0; n_orphan = 0;
        first_lb = -1; exp_r = 0; exp_c = 0; first_border = 4'd0; fd_border = 4'd0;
    endtask

    // Observe outputs mid-cycle and compare every window against the raster-order model
    task automatic sample();
        logic [3:0] exp_b;
        logic       exp_last;
        if (win_valid) begin
            exp_b    = {exp_r == 0, exp_r == H - 1, exp_c == 0, exp_c == W - 2};
            exp_last = (exp_r == H - 1) && (exp_c == W - 2);
            if (n_wv == 0) begin
                first_lb     = n_lb;
                first_border = border;
            end
            check("win_row", 32'(center_row), 32'(exp_r));
            check("win_col", 32'(center_col), 32'(exp_c));
            check("win_border", 32'(border), 32'(exp_b));
            check("win_frame_done", 32'(frame_done), 32'(exp_last));
            if (frame_done) begin
                n_fd++;
                fd_border = border;
            end
            n_wv++;
            if (exp_c == W - 2) begin
                exp_c = 0;
                exp_r = (exp_r == H - 1) ? 0 : exp_r + 1;
            end else begin
                exp_c++;
            end
        end else if (frame_done) begin
            n_orphan++;
        end
        if (lb_en) begin
            n_lb++;
            if (lb_data == 8'd0) n_zero++;
        end
        if (err_abort) n_abort++;
        if (err_overrun) n_ovr++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit start, input int n, input bit gap,
                             input logic [7:0] ovr, input bit chain);
        if (start) begin
            frame_start = 1'b1;
            pix_en_in   = 1'b0;
            tick();
            frame_start = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            pix_en_in   = 1'b1;
            pix_data_in = 8'(i);
            tick();
            if (gap && i != n - 1) begin
                pix_en_in = 1'b0;
                tick();
            end
        end
        if (n == W * H) begin
            for (int k = 0; k < int'(W); k++) begin
                pix_en_in   = ovr[k];
                pix_data_in = 8'hAA;
                frame_start = chain && (k == W - 1);
                tick();
            end
        end
        frame_start = 1'b0;
        pix_en_in   = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            tick();
            t++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        tick();
        tick();
    endtask

    task automatic check_frame(input int frames, input int ovr, input int abort);
        check("lb_en_cycles", 32'(n_lb), 32'(40 * frames));
        check("lb_zero_cycles", 32'(n_zero), 32'(9 * frames));
        check("win_count", 32'(n_wv), 32'(28 * frames));
        check("frame_done_count", 32'(n_fd), 32'(frames));
        check("frame_done_orphan", 32'(n_orphan), 32'd0);
        check("abort_count", 32'(n_abort), 32'(abort));
        check("overrun_count", 32'(n_ovr), 32'(ovr));
        check("first_win_latency", 32'(first_lb), 32'd10);
        check("first_border", 32'(first_border), 32'b1010);
        check("last_border", 32'(fd_border), 32'b0101);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        reset_mon();
        #12;
        check("rst_flags", 32'({lb_en, win_valid, busy, frame_done, err_abort, err_overrun, border}), 32'd0);
        check("rst_center", {center_row, center_col}, 32'd0);
        check("rst_lb_data", 32'(lb_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean back-to-back frame
        reset_mon();
        run_frame(1'b1, 32, 1'b0, 8'h00, 1'b0);
        wait_idle();
        check_frame(1, 0, 0);

        // pix_en_in toggling 1/0
        reset_mon();
        run_frame(1'b1, 32, 1'b1, 8'h00, 1'b0);
        wait_idle();
        check_frame(1, 0, 0);

        // Abort after 13 pixels, then a clean frame
        run_frame(1'b1, 13, 1'b0, 8'h00, 1'b0);
        tick();
        reset_mon();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        run_frame(1'b0, 32, 1'b0, 8'h00, 1'b0);
        wait_idle();
        check_frame(1, 0, 1);

        // pix_en_in during flush cycles 2 and 3
        reset_mon();
        run_frame(1'b1, 32, 1'b0, 8'b0000_0110, 1'b0);
        wait_idle();
        check_frame(1, 2, 0);

        // Asynchronous reset at pixel 20
        run_frame(1'b1, 20, 1'b0, 8'h00, 1'b0);
        pix_en_in   = 1'b1;
        pix_data_in = 8'd20;
        #2 rst_n = 1'b0;
        #1;
        check("arst_flags", 32'({lb_en, win_valid, busy, frame_done, err_abort, err_overrun, border}), 32'd0);
        check("arst_center", {center_row, center_col}, 32'd0);
        check("arst_lb_data", 32'(lb_data), 32'd0);
        pix_en_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        reset_mon();
        for (int i = 0; i < 5; i++) begin
            pix_en_in   = 1'b1;
            pix_data_in = 8'(i + 1);
            tick();
        end
        pix_en_in = 1'b0;
        tick();
        check("idle_overrun", 32'(n_ovr), 32'd5);
        check("idle_lb_en", 32'(n_lb), 32'd0);
        check("idle_win", 32'(n_wv), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        reset_mon();
        run_frame(1'b1, 32, 1'b0, 8'h00, 1'b0);
        wait_idle();
        check_frame(1, 0, 0);

        // frame_start on the last flush cycle chains a second frame
        reset_mon();
        run_frame(1'b1, 32, 1'b0, 8'h00, 1'b1);
        check("chain_busy", 32'(busy), 32'd1);
        run_frame(1'b0, 32, 1'b0, 8'h00, 1'b0);
        wait_idle();
        check_frame(2, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
